// File: rtl/iec_pkg.sv
// Shared definitions for the IEC bus conditioner.
//   IEC_ATN / IEC_CLK / IEC_DATA : index of each line in the 3-bit line vectors
//   FILT_CNT_W                   : width of the per-line stability counter
//   IEC_MAX_DRIVES               : largest supported NUM_DRIVES
package iec_pkg;

  localparam int IEC_ATN        = 0;
  localparam int IEC_CLK        = 1;
  localparam int IEC_DATA       = 2;
  localparam int IEC_NUM_LINES  = 3;

  localparam int FILT_CNT_W     = 4;
  localparam int IEC_MAX_DRIVES = 4;

endpackage

// File: rtl/iec_line_filter.sv
// Single-line glitch filter: 2-flop synchronizer followed by a stability
// counter. The filtered output only follows the synchronized input after it
// has disagreed with the current filtered value for FILT_LEN consecutive
// cycles.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (output returns to 1)
//   raw_i   : asynchronous/raw line level
//   filt_o  : filtered line level (registered)
module iec_line_filter
  import iec_pkg::*;
#(
  parameter int FILT_LEN = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic                  sync1_q, sync2_q;
  logic                  filt_q, filt_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized line disagrees with the
  // filtered value; any agreement restarts the count, so short pulses die.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + FILT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/iec_bus_conditioner.sv
// IEC serial-bus front end for multi-drive builds.
// Resolves the wired-AND CLK/DATA bus from the host and NUM_DRIVES drives
// (including ATN auto-acknowledge), filters ATN/CLK/DATA, flags ATN falling
// edges and generates the drive phase strobes.
//   clk32, reset                      : clock, synchronous active-high reset
//   host_clk/host_data/host_atn       : host line levels, 1 = released
//   drv_en/drv_clk_pull/drv_data_pull : per-drive enable and pull requests
//   drv_atna                          : per-drive ATNA latch
//   turbo                             : 1 = phase period CLK_DIV/2
//   bus_clk_raw/bus_data_raw          : combinational resolved lines
//   bus_atn/bus_clk/bus_data          : filtered lines
//   atn_fall                          : one-cycle strobe after bus_atn falls
//   p2_h_r/p2_h_f                     : phase rising/falling strobes
module iec_bus_conditioner
  import iec_pkg::*;
#(
  parameter int NUM_DRIVES = 2,   // 1..IEC_MAX_DRIVES
  parameter int FILT_LEN   = 2,   // 1..15
  parameter int CLK_DIV    = 32   // even, >= 4
) (
  input  logic                  clk32,
  input  logic                  reset,
  input  logic                  host_clk,
  input  logic                  host_data,
  input  logic                  host_atn,
  input  logic [NUM_DRIVES-1:0] drv_en,
  input  logic [NUM_DRIVES-1:0] drv_clk_pull,
  input  logic [NUM_DRIVES-1:0] drv_data_pull,
  input  logic [NUM_DRIVES-1:0] drv_atna,
  input  logic                  turbo,
  output logic                  bus_clk_raw,
  output logic                  bus_data_raw,
  output logic                  bus_atn,
  output logic                  bus_clk,
  output logic                  bus_data,
  output logic                  atn_fall,
  output logic                  p2_h_r,
  output logic                  p2_h_f
);

  // ---------------- bus resolution ----------------
  logic                  atn_asserted;
  logic [NUM_DRIVES-1:0] clk_pull;
  logic [NUM_DRIVES-1:0] data_pull;

  assign atn_asserted = ~host_atn;

  // A drive whose ATNA latch disagrees with the raw ATN state holds DATA low
  // in hardware, independent of its CPU.
  for (genvar gi = 0; gi < NUM_DRIVES; gi++) begin : g_drive
    assign clk_pull[gi]  = drv_en[gi] & drv_clk_pull[gi];
    assign data_pull[gi] = drv_en[gi] & (drv_data_pull[gi] | (drv_atna[gi] ^ atn_asserted));
  end

  assign bus_clk_raw  = host_clk  & ~|clk_pull;
  assign bus_data_raw = host_data & ~|data_pull;

  // ---------------- line filters ----------------
  logic [IEC_NUM_LINES-1:0] raw_lines;
  logic [IEC_NUM_LINES-1:0] filt_lines;

  assign raw_lines[IEC_ATN]  = host_atn;
  assign raw_lines[IEC_CLK]  = bus_clk_raw;
  assign raw_lines[IEC_DATA] = bus_data_raw;

  for (genvar gi = 0; gi < IEC_NUM_LINES; gi++) begin : g_filt
    iec_line_filter #(
      .FILT_LEN (FILT_LEN)
    ) u_filt (
      .clk_i   (clk32),
      .reset_i (reset),
      .raw_i   (raw_lines[gi]),
      .filt_o  (filt_lines[gi])
    );
  end

  assign bus_atn  = filt_lines[IEC_ATN];
  assign bus_clk  = filt_lines[IEC_CLK];
  assign bus_data = filt_lines[IEC_DATA];

  // ---------------- ATN falling-edge strobe ----------------
  logic atn_prev_q;
  logic atn_fall_q;

  always_ff @(posedge clk32) begin
    if (reset) begin
      atn_prev_q <= 1'b1;
      atn_fall_q <= 1'b0;
    end else begin
      atn_prev_q <= bus_atn;
      atn_fall_q <= atn_prev_q & ~bus_atn;
    end
  end

  assign atn_fall = atn_fall_q;

  // ---------------- phase generator ----------------
  localparam int               PER_W    = $clog2(CLK_DIV + 1);
  localparam logic [PER_W-1:0] PER_FULL = PER_W'(CLK_DIV);
  localparam logic [PER_W-1:0] PER_HALF = PER_W'(CLK_DIV / 2);

  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic             p2_r_q, p2_f_q;

  // The period is only re-sampled from turbo at the wrap, so a mid-period
  // turbo change never produces a truncated or stretched phase.
  always_comb begin
    cnt_d = cnt_q + PER_W'(1);
    per_d = per_q;
    if (cnt_q == per_q - PER_W'(1)) begin
      cnt_d = '0;
      per_d = turbo ? PER_HALF : PER_FULL;
    end
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      cnt_q  <= '0;
      per_q  <= PER_FULL;
      p2_r_q <= 1'b0;
      p2_f_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      p2_r_q <= (cnt_q == '0);
      p2_f_q <= (cnt_q == (per_q >> 1));
    end
  end

  assign p2_h_r = p2_r_q;
  assign p2_h_f = p2_f_q;

endmodule

// File: tb/tb_iec_bus_conditioner.sv
module tb_iec_bus_conditioner;

  localparam int NUM_DRIVES = 2;
  localparam int FILT_LEN   = 2;
  localparam int CLK_DIV    = 32;

  logic                  clk32 = 1'b0;
  logic                  reset;
  logic                  host_clk, host_data, host_atn;
  logic [NUM_DRIVES-1:0] drv_en, drv_clk_pull, drv_data_pull, drv_atna;
  logic                  turbo;
  logic                  bus_clk_raw, bus_data_raw;
  logic                  bus_atn, bus_clk, bus_data, atn_fall;
  logic                  p2_h_r, p2_h_f;

  int compared   = 0;
  int mismatched = 0;

  iec_bus_conditioner #(
    .NUM_DRIVES (NUM_DRIVES),
    .FILT_LEN   (FILT_LEN),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk32         (clk32),
    .reset         (reset),
    .host_clk      (host_clk),
    .host_data     (host_data),
    .host_atn      (host_atn),
    .drv_en        (drv_en),
    .drv_clk_pull  (drv_clk_pull),
    .drv_data_pull (drv_data_pull),
    .drv_atna      (drv_atna),
    .turbo         (turbo),
    .bus_clk_raw   (bus_clk_raw),
    .bus_data_raw  (bus_data_raw),
    .bus_atn       (bus_atn),
    .bus_clk       (bus_clk),
    .bus_data      (bus_data),
    .atn_fall      (atn_fall),
    .p2_h_r        (p2_h_r),
    .p2_h_f        (p2_h_f)
  );

  always #5 clk32 = ~clk32;

  typedef struct {
    logic [1:0] en;
    logic [1:0] clkp;
    logic [1:0] datap;
    logic [1:0] atna;
    logic       hclk;
    logic       hdata;
    logic       hatn;
    logic       exp_clk;
    logic       exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    host_clk      = 1'b1;
    host_data     = 1'b1;
    host_atn      = 1'b1;
    drv_en        = 2'b00;
    drv_clk_pull  = 2'b00;
    drv_data_pull = 2'b00;
    drv_atna      = 2'b00;
    turbo         = 1'b0;
  endtask

  // Leaves the bench 1 time unit after edge 0; the next posedge is edge 1.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk32);
    #1 reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk32);
    @(negedge clk32);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge clk32);
    @(negedge clk32);
    check("rst_bus_atn",  bus_atn,  1);
    check("rst_bus_clk",  bus_clk,  1);
    check("rst_bus_data", bus_data, 1);
    check("rst_atn_fall", atn_fall, 0);
    check("rst_p2_h_r",   p2_h_r,   0);
    check("rst_p2_h_f",   p2_h_f,   0);

    // ---- combinational bus resolution table ----
    //           en     clkp   datap  atna   hclk  hdata hatn  clk   data
    vecs[0]  = '{2'b00, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2'b00, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{2'b11, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{2'b01, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{2'b10, 2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drv_en        = vecs[i].en;
      drv_clk_pull  = vecs[i].clkp;
      drv_data_pull = vecs[i].datap;
      drv_atna      = vecs[i].atna;
      host_clk      = vecs[i].hclk;
      host_data     = vecs[i].hdata;
      host_atn      = vecs[i].hatn;
      #1;
      check($sformatf("vec%0d_clk_raw", i),  bus_clk_raw,  vecs[i].exp_clk);
      check($sformatf("vec%0d_data_raw", i), bus_data_raw, vecs[i].exp_data);
      $display("vec %0d: en=%b clkp=%b datap=%b atna=%b host=%b%b%b -> clk_raw=%b data_raw=%b",
               i, drv_en, drv_clk_pull, drv_data_pull, drv_atna,
               host_clk, host_data, host_atn, bus_clk_raw, bus_data_raw);
    end

    // ---- phase generator, normal period ----
    idle_inputs();
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      tick();
      check($sformatf("ph_r_c%0d", n), p2_h_r, (n == 1 || n == 33 || n == 65) ? 1 : 0);
      check($sformatf("ph_f_c%0d", n), p2_h_f, (n == 17 || n == 49) ? 1 : 0);
    end
    $display("phase normal: 70 cycles checked");

    // ---- phase generator, turbo raised at cycle 10 ----
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      tick();
      check($sformatf("tb_r_c%0d", n), p2_h_r,
            (n == 1 || (n >= 33 && (n - 33) % 16 == 0)) ? 1 : 0);
      check($sformatf("tb_f_c%0d", n), p2_h_f,
            (n == 17 || (n >= 41 && (n - 41) % 16 == 0)) ? 1 : 0);
      if (n == 10) turbo = 1'b1;
    end
    $display("phase turbo: 100 cycles checked");

    // ---- ATN assertion with auto-acknowledge ----
    idle_inputs();
    drv_en = 2'b11;
    do_reset();
    host_atn = 1'b0;
    #1;
    check("atn_data_raw_same_cycle", bus_data_raw, 0);
    for (int n = 1; n <= 7; n++) begin
      tick();
      check($sformatf("atn_bus_atn_c%0d", n),  bus_atn,  (n >= 4) ? 0 : 1);
      check($sformatf("atn_bus_data_c%0d", n), bus_data, (n >= 4) ? 0 : 1);
      check($sformatf("atn_fall_c%0d", n),     atn_fall, (n == 5) ? 1 : 0);
    end
    $display("atn: bus_atn=%b bus_data=%b", bus_atn, bus_data);
    drv_atna = 2'b10;
    #1;
    check("atna1_drive0_holds", bus_data_raw, 0);
    drv_atna = 2'b11;
    #1;
    check("atna_both_release", bus_data_raw, 1);
    drv_atna  = 2'b00;
    drv_en    = 2'b00;
    host_data = 1'b0;
    #1;
    check("dis_tracks_host0", bus_data_raw, 0);
    host_data = 1'b1;
    #1;
    check("dis_tracks_host1", bus_data_raw, 1);
    $display("drive release/disable: data_raw=%b", bus_data_raw);

    // ---- 1-cycle glitch on CLK is rejected ----
    idle_inputs();
    do_reset();
    host_clk = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk32);
      if (n == 1) #1 host_clk = 1'b1;
      @(negedge clk32);
      check($sformatf("glitch_bus_clk_c%0d", n), bus_clk, 1);
    end
    $display("glitch: bus_clk=%b", bus_clk);

    // ---- 3-cycle pulse on CLK passes ----
    do_reset();
    host_clk = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk32);
      if (n == 3) #1 host_clk = 1'b1;
      @(negedge clk32);
      check($sformatf("pulse_bus_clk_c%0d", n), bus_clk, (n >= 4 && n <= 6) ? 0 : 1);
    end
    $display("pulse: bus_clk=%b", bus_clk);

    // ---- reset in the middle of a pending transition ----
    do_reset();
    host_clk = 1'b0;
    host_atn = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      check($sformatf("mid_pre_clk_c%0d", n), bus_clk, 1);
    end
    reset = 1'b1;
    tick();
    check("mid_rst_bus_clk",  bus_clk,  1);
    check("mid_rst_bus_atn",  bus_atn,  1);
    check("mid_rst_bus_data", bus_data, 1);
    check("mid_rst_atn_fall", atn_fall, 0);
    reset = 1'b0;
    for (int n = 5; n <= 9; n++) begin
      tick();
      check($sformatf("mid_post_clk_c%0d", n), bus_clk, (n >= 8) ? 0 : 1);
      check($sformatf("mid_post_atn_c%0d", n), bus_atn, (n >= 8) ? 0 : 1);
      check($sformatf("mid_post_fall_c%0d", n), atn_fall, (n == 9) ? 1 : 0);
    end
    $display("reset mid-filter: bus_clk=%b bus_atn=%b", bus_clk, bus_atn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iec_bus_conditioner.md
Name: iec_bus_conditioner

Overview:
Parametrised IEC serial-bus front end for multi-drive builds.
- Resolves the wired-AND bus across the host and NUM_DRIVES drives, including per-drive ATN auto-acknowledge.
- Filters the resolved ATN/CLK/DATA lines with a configurable stability count.
- Generates the drive CPU/VIA phase strobes with a selectable turbo period.
- Replaces the per-drive 2-flop sync and fixed 32-cycle phase divider.

Parameters:
NUM_DRIVES, 2, number of drive ports (1..4).
FILT_LEN, 2, consecutive post-sync samples required before a filtered line changes (1..15).
CLK_DIV, 32, phase period in clk32 cycles; must be even and >=4.

Ports:
clk32  in  1  system clock.
reset  in  1  synchronous, active-high reset.
host_clk  in  1  host CLK level; 1 = released.
host_data  in  1  host DATA level; 1 = released.
host_atn  in  1  host ATN level; 1 = released.
drv_en  in  NUM_DRIVES  per-drive enable; 0 = drive fully released.
drv_clk_pull  in  NUM_DRIVES  1 = drive i pulls CLK low.
drv_data_pull  in  NUM_DRIVES  1 = drive i pulls DATA low.
drv_atna  in  NUM_DRIVES  drive i ATNA latch (VIA PB4).
turbo  in  1  1 = phase period CLK_DIV/2.
bus_clk_raw  out  1  resolved CLK line, combinational.
bus_data_raw  out  1  resolved DATA line, combinational.
bus_atn  out  1  filtered ATN.
bus_clk  out  1  filtered CLK.
bus_data  out  1  filtered DATA.
atn_fall  out  1  one-cycle strobe when filtered ATN goes 1->0.
p2_h_r  out  1  phase rising strobe.
p2_h_f  out  1  phase falling strobe.

Behaviour:
Bus resolution (combinational)
- atn_asserted = ~host_atn (raw line, unfiltered).
- Drive i pulls DATA when drv_en[i] & (drv_data_pull[i] | (drv_atna[i] ^ atn_asserted)).
- Drive i pulls CLK when drv_en[i] & drv_clk_pull[i].
- bus_clk_raw = host_clk & ~|clk pulls.
- bus_data_raw = host_data & ~|data pulls.
- ATN is host-driven only.

Line filter (one per line: host_atn, bus_clk_raw, bus_data_raw)
- 2-flop synchronizer, then a 4-bit counter.
- Counter compare: sync output vs filtered value.
  - If they differ: counter increments. When the counter reaches FILT_LEN-1 and they still differ, filtered takes the sync value and the counter clears.
  - If they are equal: counter clears.
- Latency from a raw change to the filtered change is 2+FILT_LEN clk32 cycles.
- Any pulse shorter than FILT_LEN post-sync cycles is rejected.
- Reset: sync flops = 1, filtered = 1, counter = 0.

atn_fall
- Registered; high for exactly one cycle after bus_atn transitions 1->0.
- Reset value 0.

Phase generator
- Counter cnt runs 0..P-1. P is latched from turbo (CLK_DIV or CLK_DIV/2) only when cnt wraps to 0.
- A turbo change mid-period therefore takes effect at the next period.
- Strobes are registered: p2_h_r <= (cnt==0), p2_h_f <= (cnt==P/2).
- Reset: cnt=0, P=CLK_DIV, strobes 0. First p2_h_r is asserted in the cycle after reset deasserts.
- p2_h_r and p2_h_f are never high together.

Boundary and mid-operation rules
- All drives disabled: bus lines equal the host lines.
- Reset mid-filter: a pending transition is discarded and outputs return to 1 within one cycle.
- Reset mid-period: the phase restarts at cnt=0.
- drv_en deasserted mid-transfer: that drive's pull is released in the same cycle (combinational path).

Decomposition:
- Shared package iec_pkg:
  - line index constants IEC_ATN=0, IEC_CLK=1, IEC_DATA=2;
  - filter counter width constant FILT_CNT_W=4;
  - max drive count constant IEC_MAX_DRIVES=4.
- One sub-module, iec_line_filter (parameter FILT_LEN), instantiated three times.
- The phase generator stays inline.

Test Plan:
- Reset, then idle with CLK_DIV=32, turbo=0 -> p2_h_r at cycles 1, 33, 65; p2_h_f at cycles 17, 49; never coincident.
- Assert turbo at cycle 10 -> period stays 32 until the cycle-32 wrap, then p2_h_r every 16 cycles.
- host_atn 1->0 with NUM_DRIVES=2, both enabled, drv_atna=0 -> bus_data_raw=0 in the same cycle; bus_atn=0 after 4 cycles (FILT_LEN=2); atn_fall high for 1 cycle.
- Set drv_atna[1]=1 while ATN asserted -> drive 1 releases; DATA stays low through drive 0.
- drv_en=00 -> bus_data_raw tracks host_data.
- 1-cycle low glitch on host_clk, FILT_LEN=2 -> bus_clk remains 1.
- 3-cycle low pulse on host_clk -> bus_clk=0 after 4 cycles, returns to 1 four cycles after the line releases.
- Assert reset mid-filter, 1 cycle after the sync output changes -> all filtered outputs 1, atn_fall 0, counters clear. After reset, a new 2-cycle-stable change is required before any update.
